// File: rtl/ecpeta_error_recovery.sv
// Digit-serial exact re-adder that checks and repairs an ECPETA approximate sum.
// Optional statistics counters are built only when ECPETA_ERR_STATS_EN is defined.
module ecpeta_error_recovery #(
  parameter int unsigned N     = 16,
  parameter int unsigned K     = 8,
  parameter int unsigned DIGIT = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [N-1:0]       a_i,
  input  logic [N-1:0]       b_i,
  input  logic [N-1:0]       approx_sum_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [N-1:0]       exact_sum_o,
  output logic               exact_cout_o,
  output logic [N:0]         err_o,
  output logic               mismatch_o,
  output logic               err_in_upper_o,
  output logic [CNT_W-1:0]   err_cnt_o,
  output logic [CNT_W+N-1:0] abs_err_acc_o
);

  localparam int unsigned NumDigits = N / DIGIT;
  localparam int unsigned DigW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StCmp, StDone} state_e;

  state_e          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    approx_q;
  logic            carry_q;
  logic [DigW-1:0] dig_q;
  logic [N-1:0]    exact_sum_q;
  logic            exact_cout_q;
  logic [N:0]      err_q;
  logic            mismatch_q;
  logic            upper_q;

  logic [DIGIT:0]  dig_sum;
  logic [N:0]      err_calc;
  logic            mismatch_calc;
  logic            upper_calc;

  always_comb begin
    dig_sum = {1'b0, a_q[dig_q*DIGIT +: DIGIT]} + {1'b0, b_q[dig_q*DIGIT +: DIGIT]}
              + {{DIGIT{1'b0}}, carry_q};
    // err uses the truncated sum, so overflow never leaks into the error distance
    err_calc      = {1'b0, exact_sum_q} - {1'b0, approx_q};
    mismatch_calc = (exact_sum_q != approx_q);
    upper_calc    = (exact_sum_q[N-1 -: K] != approx_q[N-1 -: K]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      approx_q     <= '0;
      carry_q      <= 1'b0;
      dig_q        <= '0;
      exact_sum_q  <= '0;
      exact_cout_q <= 1'b0;
      err_q        <= '0;
      mismatch_q   <= 1'b0;
      upper_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i && in_ready_q) begin
            a_q        <= a_i;
            b_q        <= b_i;
            approx_q   <= approx_sum_i;
            carry_q    <= 1'b0;
            dig_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StAdd;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        StAdd: begin
          exact_sum_q[dig_q*DIGIT +: DIGIT] <= dig_sum[DIGIT-1:0];
          carry_q <= dig_sum[DIGIT];
          dig_q   <= dig_q + DigW'(1);
          if (dig_q == DigW'(NumDigits - 1)) begin
            exact_cout_q <= dig_sum[DIGIT];
            state_q      <= StCmp;
          end
        end
        StCmp: begin
          err_q       <= err_calc;
          mismatch_q  <= mismatch_calc;
          upper_q     <= upper_calc;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = out_valid_q;
  assign exact_sum_o    = exact_sum_q;
  assign exact_cout_o   = exact_cout_q;
  assign err_o          = err_q;
  assign mismatch_o     = mismatch_q;
  assign err_in_upper_o = upper_q;

`ifdef ECPETA_ERR_STATS_EN
  logic [CNT_W-1:0]   err_cnt_q;
  logic [CNT_W+N-1:0] abs_acc_q;
  logic [N:0]         err_neg;
  logic [N-1:0]       abs_err;
  logic [CNT_W+N:0]   acc_sum;

  // |err| always fits in N bits because err is bounded by 2^N-1 in magnitude
  always_comb begin
    err_neg = -err_calc;
    abs_err = err_calc[N] ? err_neg[N-1:0] : err_calc[N-1:0];
    acc_sum = {1'b0, abs_acc_q} + {{(CNT_W+1){1'b0}}, abs_err};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
      abs_acc_q <= '0;
    end else if (state_q == StCmp) begin
      if (mismatch_calc && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
      abs_acc_q <= acc_sum[CNT_W+N] ? '1 : acc_sum[CNT_W+N-1:0];
    end
  end

  assign err_cnt_o     = err_cnt_q;
  assign abs_err_acc_o = abs_acc_q;
`else
  assign err_cnt_o     = '0;
  assign abs_err_acc_o = '0;
`endif

endmodule
